// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the FFT peak detector.
// Holds default widths (DATA_W, BIN_W, PWR_W) and the frame state enum.
package fft_pkg;
  localparam int DATA_W = 18;
  localparam int BIN_W  = 10;
  localparam int PWR_W  = 2 * DATA_W;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;
endpackage

// File: rtl/fft_pwr_sq.sv
// Two-stage |x|^2 pipeline: squares, then sum, with valid/sop/eop/bin sideband.
// Ports: clk, rst, valid/sop/eop/bin/re/im in; pwr_valid/sop/eop/bin/data out.
module fft_pwr_sq #(
  parameter int DATA_W = 18,
  parameter int BIN_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic                     sop,
  input  logic                     eop,
  input  logic [BIN_W-1:0]         bin,
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  output logic                     pwr_valid,
  output logic                     pwr_sop,
  output logic                     pwr_eop,
  output logic [BIN_W-1:0]         pwr_bin,
  output logic [2*DATA_W-1:0]      pwr_data
);
  import fft_pkg::*;

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] re_x;
  logic signed [PW-1:0] im_x;
  logic [PW-1:0]        rr_q;
  logic [PW-1:0]        ii_q;
  logic                 v_q;
  logic                 sop_q;
  logic                 eop_q;
  logic [BIN_W-1:0]     bin_q;

  // Full-width operands: (-2^(N-1))^2 needs the extra bits.
  assign re_x = {{DATA_W{re[DATA_W-1]}}, re};
  assign im_x = {{DATA_W{im[DATA_W-1]}}, im};

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      bin_q <= '0;
      rr_q  <= '0;
      ii_q  <= '0;
    end else begin
      v_q <= valid;
      if (valid) begin
        sop_q <= sop;
        eop_q <= eop;
        bin_q <= bin;
        rr_q  <= $unsigned(re_x * re_x);
        ii_q  <= $unsigned(im_x * im_x);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwr_valid <= 1'b0;
      pwr_sop   <= 1'b0;
      pwr_eop   <= 1'b0;
      pwr_bin   <= '0;
      pwr_data  <= '0;
    end else begin
      pwr_valid <= v_q;
      if (v_q) begin
        pwr_sop  <= sop_q;
        pwr_eop  <= eop_q;
        pwr_bin  <= bin_q;
        pwr_data <= rr_q + ii_q;
      end
    end
  end
endmodule

// File: rtl/fft_peak_detect.sv
// Per-bin power stream and per-frame peak search over FFT source frames.
// Ports: clk, rst, src_* in, fft_pts; pwr_*, peak_*, frame_err out.
// Option: define FFT_PEAK_SKIP_DC_EN to exclude bin 0 from the peak search.
module fft_peak_detect #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int BIN_W  = fft_pkg::BIN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     src_valid,
  input  logic                     src_sop,
  input  logic                     src_eop,
  input  logic signed [DATA_W-1:0] src_real,
  input  logic signed [DATA_W-1:0] src_imag,
  input  logic [BIN_W:0]           fft_pts,
  output logic                     pwr_valid,
  output logic [2*DATA_W-1:0]      pwr_data,
  output logic [BIN_W-1:0]         pwr_bin,
  output logic                     peak_valid,
  output logic [BIN_W-1:0]         peak_bin,
  output logic [2*DATA_W-1:0]      peak_pwr,
  output logic                     frame_err
);
  import fft_pkg::*;

  localparam int PW = 2 * DATA_W;
  localparam logic [BIN_W:0]   PTS_ONE = {{BIN_W{1'b0}}, 1'b1};
  localparam logic [BIN_W-1:0] BIN_ONE = {{(BIN_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [BIN_W-1:0] cnt;
  logic [BIN_W-1:0] bin_c;
  logic [BIN_W:0]   pts_q;
  logic [BIN_W:0]   pts_c;
  logic             acc;
  logic             first;
  logic             last;
  logic             good_end;
  logic             bad_end;
  logic             restart;
  logic             q_sop;
  logic             q_eop;
  logic [PW-1:0]    trk_pwr;
  logic [PW-1:0]    cand_pwr;
  logic [BIN_W-1:0] trk_bin;
  logic [BIN_W-1:0] cand_bin;

  always_comb begin
    acc   = 1'b0;
    first = 1'b0;
    bin_c = cnt;
    pts_c = pts_q;
    unique case (1'b1)
      src_valid & src_sop: begin
        acc   = 1'b1;
        first = 1'b1;
        bin_c = '0;
        pts_c = fft_pts;
      end
      src_valid & ~src_sop & (state == IN_FRAME): acc = 1'b1;
      default: ;
    endcase
  end

  assign last     = ({1'b0, bin_c} == pts_c - PTS_ONE);
  assign good_end = acc & src_eop & last;
  // eop early, or last bin without eop
  assign bad_end  = acc & (src_eop ^ last);
  assign restart  = src_valid & src_sop & (state == IN_FRAME);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pts_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= restart | bad_end;
      if (acc) begin
        pts_q <= pts_c;
        if (src_eop | last) begin
          state <= IDLE;
        end else begin
          state <= IN_FRAME;
          cnt   <= bin_c + BIN_ONE;
        end
      end
    end
  end

  fft_pwr_sq #(
    .DATA_W (DATA_W),
    .BIN_W  (BIN_W)
  ) u_sq (
    .clk       (clk),
    .rst       (rst),
    .valid     (acc),
    .sop       (first),
    .eop       (good_end),
    .bin       (bin_c),
    .re        (src_real),
    .im        (src_imag),
    .pwr_valid (pwr_valid),
    .pwr_sop   (q_sop),
    .pwr_eop   (q_eop),
    .pwr_bin   (pwr_bin),
    .pwr_data  (pwr_data)
  );

  // Strict '>' keeps the lowest bin on ties.
  always_comb begin
    cand_pwr = trk_pwr;
    cand_bin = trk_bin;
    if (q_sop) begin
`ifdef FFT_PEAK_SKIP_DC_EN
      cand_pwr = '0;
      cand_bin = '0;
`else
      cand_pwr = pwr_data;
      cand_bin = pwr_bin;
`endif
    end else if (pwr_data > trk_pwr) begin
      cand_pwr = pwr_data;
      cand_bin = pwr_bin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_pwr    <= '0;
      trk_bin    <= '0;
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_pwr   <= '0;
    end else begin
      peak_valid <= pwr_valid & q_eop;
      if (pwr_valid) begin
        trk_pwr <= cand_pwr;
        trk_bin <= cand_bin;
        if (q_eop) begin
          peak_bin <= cand_bin;
          peak_pwr <= cand_pwr;
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect with a scoreboard of expected outputs.
// Honors FFT_PEAK_SKIP_DC_EN for the DC-bin expectation.
module tb_fft_peak_detect;
  localparam int DW = 18;
  localparam int BW = 10;
`ifdef FFT_PEAK_SKIP_DC_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 src_valid;
  logic                 src_sop;
  logic                 src_eop;
  logic signed [DW-1:0] src_real;
  logic signed [DW-1:0] src_imag;
  logic [BW:0]          fft_pts;
  logic                 pwr_valid;
  logic [2*DW-1:0]      pwr_data;
  logic [BW-1:0]        pwr_bin;
  logic                 peak_valid;
  logic [BW-1:0]        peak_bin;
  logic [2*DW-1:0]      peak_pwr;
  logic                 frame_err;

  fft_peak_detect #(.DATA_W(DW), .BIN_W(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .src_real   (src_real),
    .src_imag   (src_imag),
    .fft_pts    (fft_pts),
    .pwr_valid  (pwr_valid),
    .pwr_data   (pwr_data),
    .pwr_bin    (pwr_bin),
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_pwr   (peak_pwr),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint d;
    int     b;
    int     c;
  } ent_t;

  ent_t   pq[$];
  ent_t   kq[$];
  int     eq[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     cur_pts = 8;
  bit     m_in = 1'b0;
  int     m_cnt = 0;
  int     m_pts = 0;
  int     m_pb = 0;
  longint m_pk = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_out();
    bit e;
    e = (pq.size() > 0) && (pq[0].c == cyc);
    chk("pwr_valid", {63'd0, pwr_valid}, {63'd0, e});
    if (e) begin
      chk("pwr_data", {28'd0, pwr_data}, pq[0].d);
      chk("pwr_bin", {54'd0, pwr_bin}, 64'(pq[0].b));
      void'(pq.pop_front());
    end
    e = (kq.size() > 0) && (kq[0].c == cyc);
    chk("peak_valid", {63'd0, peak_valid}, {63'd0, e});
    if (e) begin
      chk("peak_pwr", {28'd0, peak_pwr}, kq[0].d);
      chk("peak_bin", {54'd0, peak_bin}, 64'(kq[0].b));
      void'(kq.pop_front());
    end
    e = (eq.size() > 0) && (eq[0] == cyc);
    chk("frame_err", {63'd0, frame_err}, {63'd0, e});
    if (e) void'(eq.pop_front());
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_out();
  endtask

  // Drive one cycle and push what the reference model expects from it.
  task automatic step(input bit v, input bit sop, input bit eop,
                      input longint re, input longint im);
    bit     acc;
    bit     err;
    bit     lst;
    int     b;
    longint p;
    ent_t   en;
    tick();
    src_valid = v;
    src_sop   = sop;
    src_eop   = eop;
    src_real  = re[DW-1:0];
    src_imag  = im[DW-1:0];
    fft_pts   = cur_pts[BW:0];
    if (!v) return;
    acc = 1'b0;
    err = 1'b0;
    b   = 0;
    if (sop) begin
      err   = m_in;
      m_in  = 1'b1;
      m_pts = cur_pts;
      acc   = 1'b1;
    end else if (m_in) begin
      b   = m_cnt;
      acc = 1'b1;
    end
    if (acc) begin
      p = re * re + im * im;
      if (sop) begin
        m_pk = SKIP ? 0 : p;
        m_pb = 0;
      end else if (p > m_pk) begin
        m_pk = p;
        m_pb = b;
      end
      en.d = p; en.b = b; en.c = cyc + 2;
      pq.push_back(en);
      lst = (b == m_pts - 1);
      if (eop || lst) begin
        m_in = 1'b0;
        if (eop && lst) begin
          en.d = m_pk; en.b = m_pb; en.c = cyc + 3;
          kq.push_back(en);
        end else begin
          err = 1'b1;
        end
      end else begin
        m_cnt = b + 1;
      end
    end
    if (err) eq.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle(4);
    rst = 1'b1;
    pq.delete();
    kq.delete();
    eq.delete();
    m_in = 1'b0;
    idle(2);
    chk("rst_pwr_data", {28'd0, pwr_data}, 64'd0);
    chk("rst_pwr_bin", {54'd0, pwr_bin}, 64'd0);
    chk("rst_peak_bin", {54'd0, peak_bin}, 64'd0);
    chk("rst_peak_pwr", {28'd0, peak_pwr}, 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    src_valid = 1'b0;
    src_sop = 1'b0;
    src_eop = 1'b0;
    src_real = '0;
    src_imag = '0;
    fft_pts = 11'd8;
    do_reset();

    // ramp frame: pwr = k^2, peak at bin 7
    cur_pts = 8;
    for (int k = 0; k < 8; k++) step(1, k == 0, k == 7, k, 0);
    idle(4);
    chk("ramp_peak_bin", {54'd0, peak_bin}, 64'd7);
    chk("ramp_peak_pwr", {28'd0, peak_pwr}, 64'd49);

    // non-sop samples in IDLE are dropped
    for (int k = 0; k < 3; k++) step(1, 0, k == 2, 9, 9);
    idle(2);

    // tie at bins 2 and 5
    for (int k = 0; k < 8; k++) begin
      if (k == 2 || k == 5) step(1, k == 0, k == 7, 3, 4);
      else step(1, k == 0, k == 7, 0, 0);
    end
    idle(4);
    chk("tie_peak_bin", {54'd0, peak_bin}, 64'd2);
    chk("tie_peak_pwr", {28'd0, peak_pwr}, 64'd25);

    // most negative input, single-point frame
    cur_pts = 1;
    step(1, 1, 1, -131072, -131072);
    idle(4);
    chk("neg_peak_pwr", {28'd0, peak_pwr}, 64'd34359738368);

    // sop+eop while expecting 8 points
    cur_pts = 8;
    step(1, 1, 1, 5, 5);
    idle(3);

    // early eop at bin 5; peak must hold
    for (int k = 0; k < 6; k++) step(1, k == 0, k == 5, 7, 7);
    idle(4);
    chk("hold_peak_pwr", {28'd0, peak_pwr}, 64'd34359738368);

    // sop at bin 3 restarts the frame
    for (int k = 0; k < 3; k++) step(1, k == 0, 0, 2, 0);
    for (int k = 0; k < 8; k++) step(1, k == 0, k == 7, k + 1, 1);
    idle(4);
    chk("rst_frame_bin", {54'd0, peak_bin}, 64'd7);

    // last bin without eop
    for (int k = 0; k < 8; k++) step(1, k == 0, 0, 1, 1);
    idle(3);

    // DC-dominant frame
    for (int k = 0; k < 8; k++) step(1, k == 0, k == 7, k == 0 ? 100 : 1, 0);
    idle(4);
    chk("dc_peak_bin", {54'd0, peak_bin}, SKIP ? 64'd1 : 64'd0);

    // gapped ramp frame
    for (int k = 0; k < 8; k++) begin
      step(1, k == 0, k == 7, k, 0);
      step(0, 0, 0, 0, 0);
    end
    idle(4);
    chk("gap_peak_bin", {54'd0, peak_bin}, 64'd7);
    chk("gap_peak_pwr", {28'd0, peak_pwr}, 64'd49);

    // random 16-point frame
    cur_pts = 16;
    for (int k = 0; k < 16; k++)
      step(1, k == 0, k == 15,
           longint'($urandom_range(0, 262143)) - 131072,
           longint'($urandom_range(0, 262143)) - 131072);
    idle(4);

    // reset mid-frame at bin 4, then quiet
    cur_pts = 8;
    for (int k = 0; k < 4; k++) step(1, k == 0, 0, 6, 6);
    do_reset();
    idle(10);

    chk("pwr_left", 64'(pq.size()), 64'd0);
    chk("peak_left", 64'(kq.size()), 64'd0);
    chk("err_left", 64'(eq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
